// File: rtl/ram16k_burst_ctrl.sv
// rtl/ram16k_burst_ctrl.sv - burst FILL/READ sequencer driving the RAM16K array pins
`timescale 1ns/1ps
module ram16k_burst_ctrl #(
  parameter int AW     = 14,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_op_i,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [AW-1:0] cmd_len_i,
  input  logic [DW-1:0] cmd_seed_i,
  input  logic [DW-1:0] cmd_step_i,
  output logic          ram_e_o,
  output logic          ram_w_o,
  output logic          ram_r_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_din_o,
  input  logic [DW-1:0] ram_dout_i,
  output logic          rd_valid_o,
  output logic [DW-1:0] rd_data_o,
  output logic [AW-1:0] rd_addr_o,
  output logic [DW-1:0] csum_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] step_q, step_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] csum_q, csum_d;
  logic [RD_LAT-1:0] pv_q;
  logic [AW-1:0]     pa_q [RD_LAT];

  logic issue;
  assign issue = (state_q == S_READ);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    if (pv_q[RD_LAT-1]) begin
      csum_d = csum_q + ram_dout_i;
    end
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          addr_d = cmd_addr_i;
          data_d = cmd_seed_i;
          step_d = cmd_step_i;
          cnt_d  = cmd_len_i;
          if (cmd_len_i == '0) begin
            state_d = S_DONE;
          end else if (cmd_op_i) begin
            state_d = S_READ;
            csum_d  = '0;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_FILL, S_READ: begin
        addr_d = addr_q + AW'(1);
        data_d = data_q + step_q;
        cnt_d  = cnt_q - AW'(1);
        if (cnt_q == AW'(1)) begin
          state_d = (state_q == S_FILL) ? S_DONE : S_DRAIN;
          // DRAIN counts down the remaining read-latency cycles
          if (state_q == S_READ) cnt_d = AW'(RD_LAT - 1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - AW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      pv_q    <= '0;
      for (int i = 0; i < RD_LAT; i++) pa_q[i] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      pv_q[0] <= issue;
      pa_q[0] <= addr_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pa_q[i] <= pa_q[i-1];
      end
    end
  end

  assign ram_w_o     = (state_q == S_FILL);
  assign ram_r_o     = issue;
  assign ram_e_o     = ram_w_o | ram_r_o;
  assign ram_addr_o  = ram_e_o ? addr_q : '0;
  assign ram_din_o   = ram_w_o ? data_q : '0;
  assign rd_valid_o  = pv_q[RD_LAT-1];
  assign rd_data_o   = rd_valid_o ? ram_dout_i : '0;
  assign rd_addr_o   = rd_valid_o ? pa_q[RD_LAT-1] : '0;
  assign csum_o      = csum_q;
  assign cmd_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_ram16k_burst_ctrl.sv
// tb/tb_ram16k_burst_ctrl.sv - scoreboard bench for ram16k_burst_ctrl with a behavioural RAM16K
`timescale 1ns/1ps
module tb_ram16k_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [13:0] cmd_addr, cmd_len;
  logic [15:0] cmd_seed, cmd_step;
  logic        ram_e, ram_w, ram_r;
  logic [13:0] ram_addr, rd_addr;
  logic [15:0] ram_din, ram_dout, rd_data, csum;
  logic        rd_valid, busy, done;

  logic [15:0] mem [0:16383];
  logic [15:0] model_mem [0:16383];

  logic [29:0] wq [$];
  logic [13:0] iq [$];
  logic [29:0] rq [$];
  logic [15:0] dq [$];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  ram16k_burst_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_seed_i(cmd_seed), .cmd_step_i(cmd_step),
    .ram_e_o(ram_e), .ram_w_o(ram_w), .ram_r_o(ram_r), .ram_addr_o(ram_addr),
    .ram_din_o(ram_din), .ram_dout_i(ram_dout),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_addr_o(rd_addr),
    .csum_o(csum), .busy_o(busy), .done_o(done)
  );

  always @(posedge clk) begin
    if (ram_e && ram_w) mem[ram_addr] <= ram_din;
    if (ram_e && ram_r) ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    logic [29:0] e;
    chk("ram_e_eq_w_or_r", {31'd0, ram_e}, {31'd0, ram_w | ram_r});
    if (ram_w && ram_r) chk("w_r_exclusive", 1, 0);
    if (ram_w) begin
      if (wq.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        e = wq.pop_front();
        chk("wr_addr", {18'd0, ram_addr}, {18'd0, e[29:16]});
        chk("wr_data", {16'd0, ram_din}, {16'd0, e[15:0]});
      end
    end
    if (ram_r) begin
      if (iq.size() == 0) chk("unexpected_read_issue", 1, 0);
      else chk("issue_addr", {18'd0, ram_addr}, {18'd0, iq.pop_front()});
    end
    if (rd_valid) begin
      if (rq.size() == 0) chk("unexpected_rd_valid", 1, 0);
      else begin
        e = rq.pop_front();
        chk("rd_addr", {18'd0, rd_addr}, {18'd0, e[29:16]});
        chk("rd_data", {16'd0, rd_data}, {16'd0, e[15:0]});
      end
    end
    if (done) begin
      if (dq.size() == 0) chk("unexpected_done", 1, 0);
      else chk("csum_at_done", {16'd0, csum}, {16'd0, dq.pop_front()});
    end
  end

  // Entered and left at 1ns after a rising edge with the DUT idle.
  task automatic run_cmd(input logic op, input logic [13:0] addr, input logic [13:0] len,
                         input logic [15:0] seed, input logic [15:0] step,
                         input int exp_lat, input logic [15:0] exp_csum);
    int lat;
    lat = 0;
    for (int k = 0; k < int'(len); k++) begin
      logic [13:0] a;
      logic [15:0] d;
      a = addr + 14'(k);
      d = seed + 16'(k) * step;
      if (!op) begin
        wq.push_back({a, d});
        model_mem[a] = d;
      end else begin
        iq.push_back(a);
        rq.push_back({a, model_mem[a]});
      end
    end
    dq.push_back(exp_csum);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_len = len;
    cmd_seed = seed; cmd_step = step;
    chk("cmd_ready_before_accept", {31'd0, cmd_ready}, 1);
    @(posedge clk); #1;
    // keep offering junk while busy: it must be ignored
    cmd_op = ~op; cmd_addr = 14'h1234; cmd_len = 14'd7; cmd_seed = 16'hDEAD; cmd_step = 16'h0101;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      chk("busy_during_cmd", {31'd0, busy}, 1);
      if (done) begin
        lat = cyc;
        cmd_valid = 1'b0;
        break;
      end
    end
    if (lat == 0) begin
      chk("done_timeout", 1, 0);
      cmd_valid = 1'b0;
    end else chk("done_latency", lat, exp_lat);
    @(posedge clk); #1;
    chk("writes_left", wq.size(), 0);
    chk("issues_left", iq.size(), 0);
    chk("reads_left", rq.size(), 0);
    chk("dones_left", dq.size(), 0);
    chk("ready_after_done", {31'd0, cmd_ready}, 1);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = '0; cmd_len = '0;
    cmd_seed = '0; cmd_step = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
    chk("rst_ram_ewr", {29'd0, ram_e, ram_w, ram_r}, 0);
    chk("rst_busy_done", {30'd0, busy, done}, 0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 0);
    chk("rst_csum", {16'd0, csum}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_cmd(1'b0, 14'd1000, 14'd4, 16'd5, 16'd3, 5, 16'd0);
    run_cmd(1'b1, 14'd1000, 14'd4, 16'd0, 16'd0, 6, 16'd38);
    run_cmd(1'b0, 14'd16382, 14'd4, 16'hFFFE, 16'd1, 5, 16'd38);
    // FFFE+FFFF+0000+0001 = 1FFFE, truncated to 16 bits
    run_cmd(1'b1, 14'd16382, 14'd4, 16'd0, 16'd0, 6, 16'hFFFE);
    run_cmd(1'b0, 14'd500, 14'd0, 16'd9, 16'd9, 1, 16'hFFFE);
    run_cmd(1'b1, 14'd500, 14'd0, 16'd0, 16'd0, 1, 16'hFFFE);

    // reset during the second issue of an 8-word READ
    iq.push_back(14'd1000);
    iq.push_back(14'd1001);
    rq.push_back({14'd1000, 16'd5});
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = 14'd1000; cmd_len = 14'd8;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_cmd_ready", {31'd0, cmd_ready}, 1);
    chk("abort_ram_e", {31'd0, ram_e}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_csum", {16'd0, csum}, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_issues_left", iq.size(), 0);
    chk("abort_reads_left", rq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
